// File: rtl/avalon_ram_responder_if.sv
// Avalon-MM bus between the CPU master and the RAM responder.
// Carries address, request strobes, write data with lane enables,
// read data and the waitrequest stall back to the master.
interface avalon_ram_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave RAM standing in for instruction/data memory.
// Word-addressed storage mapped at BASE_ADDR, WAIT_CYCLES stalled cycles
// before each completing cycle, a bench preload port and sticky
// protocol-violation flags.
// Optional build macro AVALON_RAM_BYTEENABLE_EN: when defined, writes honour
// byteenable per lane; when undefined every write updates all 32 bits.
module avalon_ram_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_ram_responder_if.slave bus,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  err_misalign,
    output logic                  err_range,
    output logic                  err_rw
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Counter only ever holds WAIT_CYCLES-1 down to 0.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]           mem_q [DEPTH];
    logic                  err_misalign_q, err_range_q, err_rw_q;

    logic                  req;
    logic                  stall;
    logic                  complete;
    logic                  done;
    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] index;
    logic                  rw_both;
    logic                  wr_en;
    logic                  rd_hit;
    logic [3:0]            lane_en;

    assign req     = bus.read | bus.write;
    assign rw_both = bus.read & bus.write;

    // Unsigned wrap-around makes addresses below BASE_ADDR land far out of range.
    assign offset   = bus.address - BASE_ADDR;
    assign in_range = ~|(offset >> (ADDR_WIDTH + 2));
    assign index    = offset[ADDR_WIDTH+1:2];

`ifdef AVALON_RAM_BYTEENABLE_EN
    assign lane_en = bus.byteenable;
`else
    // Port kept so both builds share one interface; the value is not used.
    logic unused_be;
    assign unused_be = ^bus.byteenable;
    assign lane_en   = 4'b1111;
`endif

    // Next-state, counter and stall/complete decode for the wait-state FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset forces the bus quiet and suppresses any completion in flight.
    assign done            = complete & ~reset;
    assign bus.waitrequest = stall & ~reset;

    assign wr_en  = done & bus.write & ~bus.read & in_range;
    assign rd_hit = done & bus.read & ~bus.write & in_range;

    assign bus.readdata = rd_hit ? mem_q[index] : 32'd0;

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory array: bus writes per lane, then preload so it wins on a collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[index][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Sticky protocol-violation flags, sampled only in completing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
            err_rw_q       <= 1'b0;
        end else if (done) begin
            if (bus.address[1:0] != 2'b00) err_misalign_q <= 1'b1;
            if (!in_range)                 err_range_q    <= 1'b1;
            if (rw_both)                   err_rw_q       <= 1'b1;
        end
    end

    assign err_misalign = err_misalign_q;
    assign err_range    = err_range_q;
    assign err_rw       = err_rw_q;

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Bench for avalon_ram_responder: one instance with two wait states and one
// with none, sharing a preload port, checked against an array model.
module tb_avalon_ram_responder;

    localparam int          WA    = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        erra_mis, erra_rng, erra_rw;
    logic        errb_mis, errb_rng, errb_rw;

    avalon_ram_responder_if bus_a ();
    avalon_ram_responder_if bus_b ();

    avalon_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WA), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err_misalign(erra_mis), .err_range(erra_rng), .err_rw(erra_rw)
    );

    avalon_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err_misalign(errb_mis), .err_range(errb_rng), .err_rw(errb_rw)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] model [2][DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mread(input int d, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off >= 32'(DEPTH * 4)) return 32'd0;
        return model[d][int'(off >> 2)];
    endfunction

    function automatic void mwrite(input int d, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] be);
        logic [31:0] off;
        int idx;
        off = addr - BASE;
        if (off >= 32'(DEPTH * 4)) return;
        idx = int'(off >> 2);
        for (int i = 0; i < 4; i++) begin
`ifdef AVALON_RAM_BYTEENABLE_EN
            if (be[i]) model[d][idx][8*i +: 8] = data[8*i +: 8];
`else
            if (be[i] || !be[i]) model[d][idx][8*i +: 8] = data[8*i +: 8];
`endif
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus_a.read = rd; bus_a.write = wr; bus_a.address = addr;
        bus_a.writedata = wdata; bus_a.byteenable = be;
    endtask

    task automatic drive_b(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus_b.read = rd; bus_b.write = wr; bus_b.address = addr;
        bus_b.writedata = wdata; bus_b.byteenable = be;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        load_en = 1'b1; load_addr = 10'(idx); load_data = data;
        model[0][idx] = data; model[1][idx] = data;
        next_cycle();
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    // One transfer on the two-wait-state instance; request left held at the end.
    task automatic xfer_a(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [2:0] wtrace, output logic [31:0] stall_rd,
                          output logic [31:0] done_rd, output logic [2:0] err_seen);
        drive_a(rd, wr, addr, wdata, be);
        wtrace = '0; stall_rd = '0; done_rd = '0; err_seen = '0;
        for (int k = 0; k <= WA; k++) begin
            @(negedge clk);
            wtrace[k] = bus_a.waitrequest;
            err_seen  = err_seen | {erra_mis, erra_rng, erra_rw};
            if (k < WA) stall_rd = stall_rd | bus_a.readdata;
            else        done_rd  = bus_a.readdata;
            next_cycle();
        end
    endtask

    // One single-cycle transfer on the zero-wait-state instance.
    task automatic xfer_b(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic w, output logic [31:0] rdv);
        drive_b(rd, wr, addr, wdata, be);
        @(negedge clk);
        w = bus_b.waitrequest; rdv = bus_b.readdata;
        next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_a(1, 0, BASE, 0, 4'hF); drive_b(1, 0, BASE, 0, 4'hF);
        #1;
        total_cnt++; if (bus_a.waitrequest !== 1'b0) $display("FAIL rst_wait_a got %b want 0", bus_a.waitrequest); else pass_cnt++;
        total_cnt++; if (bus_a.readdata !== 32'd0) $display("FAIL rst_rdata_a got %h want 0", bus_a.readdata); else pass_cnt++;
        total_cnt++; if (bus_b.readdata !== 32'd0) $display("FAIL rst_rdata_b got %h want 0", bus_b.readdata); else pass_cnt++;
        total_cnt++; if ({erra_mis, erra_rng, erra_rw, errb_mis, errb_rng, errb_rw} !== 6'd0)
            $display("FAIL rst_err got %b want 000000", {erra_mis, erra_rng, erra_rw, errb_mis, errb_rng, errb_rw}); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if ({bus_a.waitrequest, bus_a.readdata} !== 33'd0)
            $display("FAIL idle_out got %b/%h want 0/0", bus_a.waitrequest, bus_a.readdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) preload(i, (i == 0) ? 32'h24020005 : $urandom);
    endtask

    task automatic test_wait_read();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        xfer_a(1, 0, BASE, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (wt !== 3'b011) $display("FAIL wait_trace got %b want 011", wt); else pass_cnt++;
        total_cnt++; if (srd !== 32'd0) $display("FAIL wait_stall_rdata got %h want 0", srd); else pass_cnt++;
        total_cnt++; if (drd !== 32'h24020005) $display("FAIL wait_rdata got %h want 24020005", drd); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus_a.waitrequest !== 1'b1) $display("FAIL held_restart got %b want 1", bus_a.waitrequest); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_back_to_back();
        logic w; logic [31:0] r; logic [31:0] addr;
        xfer_b(1, 0, BASE, 0, 4'hF, w, r);
        total_cnt++; if (w !== 1'b0 || r !== 32'h24020005) $display("FAIL b2b_w0 got %b/%h want 0/24020005", w, r); else pass_cnt++;
        xfer_b(1, 0, BASE + 4, 0, 4'hF, w, r);
        total_cnt++; if (w !== 1'b0 || r !== model[1][1]) $display("FAIL b2b_w1 got %b/%h want 0/%h", w, r, model[1][1]); else pass_cnt++;
        for (int t = 0; t < 6; t++) begin
            addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            xfer_b(1, 0, addr, 0, 4'hF, w, r);
            total_cnt++; if (w !== 1'b0 || r !== mread(1, addr)) $display("FAIL b2b_rand addr %h got %b/%h want 0/%h", addr, w, r, mread(1, addr)); else pass_cnt++;
        end
        drive_b(0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_preload_visible();
        logic w; logic [31:0] r; logic [31:0] v;
        v = $urandom;
        preload(3, v);
        xfer_b(1, 0, BASE + 32'hC, 0, 4'hF, w, r);
        total_cnt++; if (r !== v) $display("FAIL preload_next got %h want %h", r, v); else pass_cnt++;
        drive_b(0, 0, 0, 0, 0);
        next_cycle();
    endtask

    task automatic test_byteenable();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es; logic [31:0] exp;
        preload(5, 32'd0);
        xfer_a(0, 1, BASE + 32'h14, 32'hDEADBEEF, 4'b0011, wt, srd, drd, es);
        total_cnt++; if (wt !== 3'b011 || drd !== 32'd0) $display("FAIL be_write got %b/%h want 011/0", wt, drd); else pass_cnt++;
        mwrite(0, BASE + 32'h14, 32'hDEADBEEF, 4'b0011);
        xfer_a(1, 0, BASE + 32'h14, 0, 4'hF, wt, srd, drd, es);
`ifdef AVALON_RAM_BYTEENABLE_EN
        exp = 32'h0000BEEF;
`else
        exp = 32'hDEADBEEF;
`endif
        total_cnt++; if (drd !== exp) $display("FAIL be_readback got %h want %h", drd, exp); else pass_cnt++;
        xfer_a(0, 1, BASE + 32'h14, 32'h12345678, 4'b0000, wt, srd, drd, es);
        mwrite(0, BASE + 32'h14, 32'h12345678, 4'b0000);
        xfer_a(1, 0, BASE + 32'h14, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== mread(0, BASE + 32'h14)) $display("FAIL be_none got %h want %h", drd, mread(0, BASE + 32'h14)); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_preload_override();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es; logic [31:0] lv;
        lv = $urandom;
        drive_a(0, 1, BASE + 32'h1C, ~lv, 4'hF);
        next_cycle(); next_cycle();
        preload(7, lv);
        xfer_a(1, 0, BASE + 32'h1C, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== lv) $display("FAIL preload_override got %h want %h", drd, lv); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_errors();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        do_reset();
        xfer_a(1, 0, 32'h00000000, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== 32'd0) $display("FAIL range_rdata got %h want 0", drd); else pass_cnt++;
        total_cnt++; if (es !== 3'b000) $display("FAIL err_early got %b want 000", es); else pass_cnt++;
        total_cnt++; if ({erra_mis, erra_rng, erra_rw} !== 3'b010) $display("FAIL err_range got %b want 010", {erra_mis, erra_rng, erra_rw}); else pass_cnt++;
        xfer_a(0, 1, 32'h00000000, 32'hA5A5A5A5, 4'hF, wt, srd, drd, es);
        xfer_a(1, 0, BASE, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== 32'h24020005) $display("FAIL range_nowrite got %h want 24020005", drd); else pass_cnt++;
        xfer_a(1, 0, BASE + 32'h2, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== 32'h24020005) $display("FAIL misalign_rdata got %h want 24020005", drd); else pass_cnt++;
        total_cnt++; if ({erra_mis, erra_rng, erra_rw} !== 3'b110) $display("FAIL err_misalign got %b want 110", {erra_mis, erra_rng, erra_rw}); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_rw_conflict();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        do_reset();
        xfer_a(1, 1, BASE + 32'h4, ~model[0][1], 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== 32'd0) $display("FAIL rw_rdata got %h want 0", drd); else pass_cnt++;
        total_cnt++; if ({erra_mis, erra_rng, erra_rw} !== 3'b001) $display("FAIL err_rw got %b want 001", {erra_mis, erra_rng, erra_rw}); else pass_cnt++;
        xfer_a(1, 0, BASE + 32'h4, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== model[0][1]) $display("FAIL rw_nowrite got %h want %h", drd, model[0][1]); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_withdraw();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        drive_a(1, 0, BASE + 32'h8, 0, 4'hF);
        @(negedge clk);
        total_cnt++; if (bus_a.waitrequest !== 1'b1) $display("FAIL wd_start got %b want 1", bus_a.waitrequest); else pass_cnt++;
        next_cycle();
        drive_a(0, 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++; if ({bus_a.waitrequest, bus_a.readdata} !== 33'd0) $display("FAIL wd_drop got %b/%h want 0/0", bus_a.waitrequest, bus_a.readdata); else pass_cnt++;
        next_cycle();
        xfer_a(1, 0, BASE + 32'h8, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (wt !== 3'b011 || drd !== model[0][2]) $display("FAIL wd_refill got %b/%h want 011/%h", wt, drd, model[0][2]); else pass_cnt++;
        drive_a(0, 1, BASE + 32'h24, ~model[0][9], 4'hF);
        next_cycle(); next_cycle();
        drive_a(0, 0, 0, 0, 0);
        next_cycle();
        xfer_a(1, 0, BASE + 32'h24, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== model[0][9]) $display("FAIL wd_nowrite got %h want %h", drd, model[0][9]); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_reset_busy();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        xfer_a(1, 0, 32'h00000000, 0, 4'hF, wt, srd, drd, es);
        drive_a(0, 0, 0, 0, 0);
        next_cycle();
        total_cnt++; if (erra_rng !== 1'b1) $display("FAIL rb_preerr got %b want 1", erra_rng); else pass_cnt++;
        drive_a(0, 1, BASE + 32'h2C, ~model[0][11], 4'hF);
        next_cycle();
        #1 reset = 1'b1;
        #1;
        total_cnt++; if (bus_a.waitrequest !== 1'b0 || bus_a.readdata !== 32'd0) $display("FAIL rb_wait got %b/%h want 0/0", bus_a.waitrequest, bus_a.readdata); else pass_cnt++;
        total_cnt++; if ({erra_mis, erra_rng, erra_rw} !== 3'b000) $display("FAIL rb_err got %b want 000", {erra_mis, erra_rng, erra_rw}); else pass_cnt++;
        next_cycle(); next_cycle();
        drive_a(0, 0, 0, 0, 0);
        reset = 1'b0;
        next_cycle();
        xfer_a(1, 0, BASE + 32'h2C, 0, 4'hF, wt, srd, drd, es);
        total_cnt++; if (drd !== model[0][11]) $display("FAIL rb_nowrite got %h want %h", drd, model[0][11]); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_random_a();
        logic [2:0] wt; logic [31:0] srd, drd; logic [2:0] es;
        logic [31:0] addr, data, exp; logic rd; logic [3:0] be;
        do_reset();
        for (int t = 0; t < 24; t++) begin
            addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            rd   = 1'($urandom_range(0, 1));
            data = $urandom;
            be   = 4'($urandom_range(0, 15));
            exp  = rd ? mread(0, addr) : 32'd0;
            xfer_a(rd, !rd, addr, data, be, wt, srd, drd, es);
            total_cnt++; if (wt !== 3'b011 || srd !== 32'd0 || drd !== exp)
                $display("FAIL rand_a t%0d addr %h got %b/%h/%h want 011/0/%h", t, addr, wt, srd, drd, exp); else pass_cnt++;
            if (!rd) mwrite(0, addr, data, be);
        end
        total_cnt++; if ({erra_mis, erra_rng, erra_rw} !== 3'b000) $display("FAIL rand_a_err got %b want 000", {erra_mis, erra_rng, erra_rw}); else pass_cnt++;
        drive_a(0, 0, 0, 0, 0);
        next_cycle(); next_cycle();
    endtask

    task automatic test_random_b();
        logic w; logic [31:0] r; logic [31:0] addr, data, exp, off;
        logic rd, wr; logic [3:0] be; logic [2:0] exp_err; int sel, op;
        exp_err = 3'b000;
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 19);
            if (sel < 15)      addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            else if (sel < 17) addr = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
            else               addr = $urandom;
            op = $urandom_range(0, 9);
            rd = (op <= 5); wr = (op == 0) || (op > 5);
            data = $urandom; be = 4'($urandom_range(0, 15));
            exp  = (rd && !wr) ? mread(1, addr) : 32'd0;
            xfer_b(rd, wr, addr, data, be, w, r);
            total_cnt++; if (w !== 1'b0 || r !== exp)
                $display("FAIL rand_b t%0d addr %h rd%b wr%b got %b/%h want 0/%h", t, addr, rd, wr, w, r, exp); else pass_cnt++;
            if (wr && !rd) mwrite(1, addr, data, be);
            off = addr - BASE;
            if (addr[1:0] != 2'b00)        exp_err[2] = 1'b1;
            if (off >= 32'(DEPTH * 4))     exp_err[1] = 1'b1;
            if (rd && wr)                  exp_err[0] = 1'b1;
        end
        total_cnt++; if ({errb_mis, errb_rng, errb_rw} !== exp_err)
            $display("FAIL rand_b_err got %b want %b", {errb_mis, errb_rng, errb_rw}, exp_err); else pass_cnt++;
        drive_b(0, 0, 0, 0, 0);
        next_cycle();
    endtask

    initial begin
        reset = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_preload();
        test_wait_read();
        test_back_to_back();
        test_preload_visible();
        test_byteenable();
        test_preload_override();
        test_errors();
        test_rw_conflict();
        test_withdraw();
        test_reset_busy();
        do_reset();
        test_random_a();
        do_reset();
        test_random_b();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
